// File: rtl/busio_pkg.sv
// Shared definitions for the serial configuration bus master.
// Holds command/error codes, FSM states, frame sizes and the reply framer.
package busio_pkg;

    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;
    localparam logic [7:0] CMD_BURST = 8'h03;
    localparam logic [7:0] CMD_ERR   = 8'hEE;

    localparam logic [7:0] ERR_LEN = 8'd1;
    localparam logic [7:0] ERR_CMD = 8'd2;
    localparam logic [7:0] ERR_TMO = 8'd3;

    localparam int RX_FRAME = 12;
    localparam int TX_FRAME = 13;

    typedef enum logic [3:0] {
        IDLE, DECODE, WRITE, RDREQ, RDWAIT,
        LOAD, REPLY, NEXT, ERR, DONE
    } state_t;

    // Reply byte: 0, 1, flag, 8 bits MSB first, 0, 0
    function automatic logic [TX_FRAME-1:0] tx_frame(
        input logic       flag,
        input logic [7:0] b
    );
        return {2'b01, flag, b, 2'b00};
    endfunction

endpackage

// File: rtl/serbus_deframer.sv
// Serial deframer: 12-bit frame detect, message buffer and command dispatch.
// Ports: clk, rst, serialin in; exec pulse, cmd byte, msg snapshot, nbytes out.
module serbus_deframer
    import busio_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serialin,
    output logic             exec,
    output logic [7:0]       cmd,
    output logic [AW+DW-1:0] msg,
    output logic [3:0]       nbytes
);
    localparam int BW = AW + DW;

    logic [RX_FRAME-1:0] sr;
    logic [BW-1:0]       buffer;
    logic [3:0]          cnt;
    logic                det;

    assign det = sr[RX_FRAME-1] & ~sr[1] & ~sr[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr     <= '0;
            buffer <= '0;
            cnt    <= '0;
            exec   <= 1'b0;
            cmd    <= '0;
            msg    <= '0;
            nbytes <= '0;
        end else begin
            exec <= 1'b0;
            if (det) begin
                // The bit arriving on the detect edge is dropped with the clear
                sr <= '0;
                if (sr[10]) begin
                    exec   <= 1'b1;
                    cmd    <= sr[9:2];
                    msg    <= buffer;
                    nbytes <= cnt;
                    buffer <= '0;
                    cnt    <= '0;
                end else begin
                    buffer <= {buffer[BW-9:0], sr[9:2]};
                    if (cnt != 4'd15) cnt <= cnt + 4'd1;
                end
            end else begin
                sr <= {sr[RX_FRAME-2:0], serialin};
            end
        end
    end

endmodule

// File: rtl/serbus_master.sv
// Serial bus master: executes WRITE/READ/BURST on the register bus and replies.
// Ports: serial in/out, wr/rd/addr/wrdata/rddata/ack bus, four event counters.
module serbus_master
    import busio_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int TIMEOUT  = 255,
    parameter int MAXBURST = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          serialin,
    output logic          serialout,
    output logic          wr,
    output logic          rd,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wrdata,
    input  logic [DW-1:0] rddata,
    input  logic          ack,
    output logic [15:0]   wrcount,
    output logic [15:0]   rdcount,
    output logic [15:0]   errcount,
    output logic [15:0]   ovrcount
);
    localparam int NB  = DW / 8;
    localparam int BW  = AW + DW;
    localparam int TXW = (NB + 1) * TX_FRAME;

    logic          exec;
    logic [7:0]    cmd;
    logic [BW-1:0] msg;
    logic [3:0]    nbytes;

    serbus_deframer #(.AW(AW), .DW(DW)) u_deframer (
        .clk      (clk),
        .rst      (rst),
        .serialin (serialin),
        .exec     (exec),
        .cmd      (cmd),
        .msg      (msg),
        .nbytes   (nbytes)
    );

    state_t         state, next;
    logic [7:0]     op, rem, errcode, bcount, dec_err;
    logic [DW-1:0]  rdword;
    logic           got;
    logic [15:0]    tcnt;
    logic [TXW-1:0] txsr, txvec;
    logic [7:0]     txcnt, txlen;

    assign bcount    = msg[AW +: 8];
    assign serialout = (state == REPLY) & txsr[TXW-1];

    always_comb begin
        dec_err = '0;
        case (cmd)
            CMD_WR:
                if (nbytes != 4'(BW/8)) dec_err = ERR_LEN;
            CMD_RD:
                if (nbytes != 4'(AW/8)) dec_err = ERR_LEN;
            CMD_BURST:
                if (nbytes != 4'(AW/8 + 1) || bcount == 8'd0 ||
                    bcount > 8'(MAXBURST))
                    dec_err = ERR_LEN;
            default:
                dec_err = ERR_CMD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:   if (exec) next = DECODE;
            DECODE: begin
                if (dec_err != 8'd0)  next = ERR;
                else if (cmd == CMD_WR) next = WRITE;
                else                  next = RDREQ;
            end
            WRITE:  next = LOAD;
            RDREQ:  next = RDWAIT;
            RDWAIT: begin
                if (got || ack)                  next = LOAD;
                else if (tcnt == 16'(TIMEOUT))   next = ERR;
            end
            LOAD:   next = REPLY;
            REPLY:  if (txcnt == 8'd1) next = NEXT;
            NEXT:   next = (rem != 8'd0) ? RDREQ : DONE;
            ERR:    next = REPLY;
            DONE:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Reply image, MSB first; a read word carries the command byte only when last
    always_comb begin
        txvec = '0;
        txlen = '0;
        if (state == ERR) begin
            txvec[TXW-1 -: 2*TX_FRAME] = {tx_frame(1'b0, errcode),
                                          tx_frame(1'b1, CMD_ERR)};
            txlen = 8'(2*TX_FRAME);
        end else if (op == CMD_WR) begin
            txvec[TXW-1 -: TX_FRAME] = tx_frame(1'b1, CMD_WR);
            txlen = 8'(TX_FRAME);
        end else begin
            for (int i = 0; i < NB; i++)
                txvec[TXW-1-TX_FRAME*i -: TX_FRAME] =
                    tx_frame(1'b0, rdword[DW-1-8*i -: 8]);
            txlen = 8'(NB*TX_FRAME);
            if (rem == 8'd0) begin
                txvec[TX_FRAME-1:0] = tx_frame(1'b1, op);
                txlen = 8'(TXW);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr <= 1'b0;  rd <= 1'b0;  addr <= '0;  wrdata <= '0;
            op <= '0;    rem <= '0;   errcode <= '0;
            rdword <= '0; got <= 1'b0; tcnt <= '0;
            txsr <= '0;  txcnt <= '0;
            wrcount <= '0; rdcount <= '0; errcount <= '0; ovrcount <= '0;
        end else begin
            wr <= 1'b0;
            if (exec && state != IDLE) ovrcount <= ovrcount + 16'd1;
            unique case (state)
                DECODE: begin
                    op  <= cmd;
                    rem <= '0;
                    if (dec_err != 8'd0) begin
                        errcode  <= dec_err;
                        errcount <= errcount + 16'd1;
                    end else begin
                        addr <= msg[AW-1:0];
                        if (cmd == CMD_WR) begin
                            wrdata <= msg[BW-1:AW];
                            wr     <= 1'b1;
                        end else begin
                            if (cmd == CMD_BURST) rem <= bcount - 8'd1;
                            rd   <= 1'b1;
                            got  <= 1'b0;
                            tcnt <= 16'd1;
                        end
                    end
                end
                WRITE: wrcount <= wrcount + 16'd1;
                RDREQ: begin
                    // An ack seen alongside the first rd cycle is honoured
                    if (ack) begin
                        got    <= 1'b1;
                        rdword <= rddata;
                        rd     <= 1'b0;
                    end
                end
                RDWAIT: begin
                    if (got || ack) begin
                        if (!got) rdword <= rddata;
                        rd      <= 1'b0;
                        rdcount <= rdcount + 16'd1;
                    end else if (tcnt == 16'(TIMEOUT)) begin
                        rd       <= 1'b0;
                        rem      <= '0;
                        errcode  <= ERR_TMO;
                        errcount <= errcount + 16'd1;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                LOAD, ERR: begin
                    txsr  <= txvec;
                    txcnt <= txlen;
                end
                REPLY: begin
                    txsr  <= txsr << 1;
                    txcnt <= txcnt - 8'd1;
                end
                NEXT: begin
                    if (rem != 8'd0) begin
                        addr <= addr + 1'b1;
                        rem  <= rem - 8'd1;
                        rd   <= 1'b1;
                        got  <= 1'b0;
                        tcnt <= 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
